// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port block RAM between two req/ack ports
module mem_port_arbiter #(
  parameter int AW = 4,
  parameter int DW = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk_g,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  input  logic [DW-1:0] mem_douta,
  output logic          mem_ena,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addra,
  output logic [DW-1:0] mem_dina,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_n;
  logic sel, sel_n, last, last_n, gnt, we_g;
  logic [1:0] cnt, cnt_n;
  logic ack0_n, ack1_n, ena_n, wea_n, busy_n;
  logic [DW-1:0] rdata0_n, rdata1_n, dina_n;
  logic [AW-1:0] addra_n;
  assign gnt = (req0 && req1) ? !last : req1;
  assign we_g = gnt ? we1 : we0;
  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n = state;
    sel_n = sel;
    last_n = last;
    cnt_n = cnt;
    ack0_n = 1'b0;
    ack1_n = 1'b0;
    ena_n = 1'b0;
    wea_n = 1'b0;
    addra_n = mem_addra;
    dina_n = mem_dina;
    rdata0_n = rdata0;
    rdata1_n = rdata1;
    case (state)
      IDLE: if (req0 || req1) begin
        sel_n = gnt;
        last_n = gnt;
        state_n = ISSUE;
        ena_n = 1'b1;
        wea_n = we_g;
        addra_n = gnt ? addr1 : addr0;
        dina_n = we_g ? (gnt ? wdata1 : wdata0) : '0;
      end
      ISSUE: if (mem_wea) begin
        state_n = ACK;
        ack0_n = !sel;
        ack1_n = sel;
      end else begin
        state_n = WAIT;
        cnt_n = 2'(RD_LAT - 1);
      end
      WAIT: if (cnt != 2'd0) cnt_n = cnt - 2'd1;
      else begin
        state_n = ACK;
        ack0_n = !sel;
        ack1_n = sel;
        rdata0_n = sel ? rdata0 : mem_douta;
        rdata1_n = sel ? mem_douta : rdata1;
      end
      ACK: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  // State and output registers; reset abandons any in-flight op and favours port 0 next
  always_ff @(posedge clk_g) begin
    if (rst) begin
      state <= IDLE;
      sel <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      mem_ena <= 1'b0;
      mem_wea <= 1'b0;
      mem_addra <= '0;
      mem_dina <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      last <= last_n;
      cnt <= cnt_n;
      ack0 <= ack0_n;
      ack1 <= ack1_n;
      rdata0 <= rdata0_n;
      rdata1 <= rdata1_n;
      mem_ena <= ena_n;
      mem_wea <= wea_n;
      mem_addra <= addra_n;
      mem_dina <= dina_n;
      busy <= busy_n;
    end
  end
endmodule
